mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/lsu_align.sv | 65 ++++++
 rtl/mem_stage.sv | 148 ++++++++++++++
 tb/tb_mem_stage.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core types: LSU opcodes, access types, tag width and MEM FSM states.
// Also hosts the misalignment rule used by the MEM stage.
package riscv_pkg;

  localparam int TAG_WIDTH = 4;

  typedef enum logic {
    LSU_OP_LD = 1'b0,
    LSU_OP_ST = 1'b1
  } lsu_op_e;

  // bit 2 = unsigned, bits 1:0 = size (byte/half/word)
  typedef enum logic [2:0] {
    LSU_LB  = 3'b000,
    LSU_LH  = 3'b001,
    LSU_LW  = 3'b010,
    LSU_LBU = 3'b100,
    LSU_LHU = 3'b101
  } lsu_dtype_e;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT_GNT,
    MEM_WAIT_RVALID,
    MEM_DONE
  } mem_state_e;

  function automatic logic is_misaligned(
    input lsu_dtype_e dt,
    input logic [1:0] off
  );
    logic [2:0] d;
    d = dt;
    is_misaligned = (d[1:0] == 2'b01 && off[0])
                  || (d[1] && off != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: byte enables, store replication
// and load extraction with sign/zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  lsu_dtype_e  dtype,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [2:0]  d;
  logic        is_byte;
  logic        is_half;
  logic [1:0]  off;
  logic [31:0] sh;

  assign d       = dtype;
  assign is_byte = d[1:0] == 2'b00;
  assign is_half = d[1:0] == 2'b01;

  // Low bits the access size cannot use are dropped.
  always_comb begin
    off       = 2'b00;
    be        = 4'b1111;
    wdata_rep = wdata;
    unique case (1'b1)
      is_byte: begin
        off       = addr_lo;
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      is_half: begin
        off       = {addr_lo[1], 1'b0};
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        off       = 2'b00;
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    rdata_ext = sh;
    unique case (1'b1)
      is_byte:
        rdata_ext = d[2] ? {24'd0, sh[7:0]}
                         : {{24{sh[7]}}, sh[7:0]};
      is_half:
        rdata_ext = d[2] ? {16'd0, sh[15:0]}
                         : {{16{sh[15]}}, sh[15:0]};
      default:
        rdata_ext = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data bus for loads/stores and
// registers the rd writeback bundle handed to WB.
module mem_stage
  import riscv_pkg::*;
#(
  parameter logic MISALIGN_EXC_EN = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_M,
  input  logic                 ready_wb,
  output logic                 ready_mem,
  input  logic                 lsu_en_mem,
  input  lsu_op_e              lsu_op_mem,
  input  lsu_dtype_e           lsu_dtype_mem,
  input  logic [31:0]          lsu_addr_mem,
  input  logic [31:0]          lsu_wdata_mem,
  input  logic                 rd_wr_en_mem,
  input  logic [TAG_WIDTH-1:0] rd_wr_tag_mem,
  input  logic [4:0]           rd_wr_addr_mem,
  input  logic [31:0]          rd_wr_data_mem,
  input  logic                 exc_taken_mem,
  output logic                 data_req,
  input  logic                 data_gnt,
  output logic                 data_we,
  output logic [3:0]           data_be,
  output logic [31:0]          data_addr,
  output logic [31:0]          data_wdata,
  input  logic                 data_rvalid,
  input  logic [31:0]          data_rdata,
  output logic                 rd_wr_en_wb,
  output logic [TAG_WIDTH-1:0] rd_wr_tag_wb,
  output logic [4:0]           rd_wr_addr_wb,
  output logic [31:0]          rd_wr_data_wb,
  output logic                 exc_taken_wb
);

  mem_state_e  state_q;
  mem_state_e  state_d;
  logic        kill_q;
  logic [31:0] hold_q;
  logic        is_st;
  logic        misal_exc;
  logic        need_bus;
  logic        bubble;
  logic [31:0] rsrc;
  logic [31:0] ld_data;

  assign is_st     = lsu_op_mem == LSU_OP_ST;
  assign misal_exc = MISALIGN_EXC_EN & lsu_en_mem
                   & is_misaligned(lsu_dtype_mem, lsu_addr_mem[1:0]);
  assign need_bus  = lsu_en_mem & ~exc_taken_mem
                   & ~flush_M & ~misal_exc;
  assign bubble    = flush_M | kill_q;

  assign data_addr = {lsu_addr_mem[31:2], 2'b00};
  assign data_we   = is_st;
  assign rsrc      = (state_q == MEM_DONE) ? hold_q : data_rdata;

  lsu_align u_align (
    .dtype     (lsu_dtype_mem),
    .addr_lo   (lsu_addr_mem[1:0]),
    .wdata     (lsu_wdata_mem),
    .rdata     (rsrc),
    .be        (data_be),
    .wdata_rep (data_wdata),
    .rdata_ext (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= MEM_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MEM_IDLE:
        if (need_bus)
          state_d = data_gnt ? MEM_WAIT_RVALID : MEM_WAIT_GNT;
      MEM_WAIT_GNT:
        if (data_gnt) state_d = MEM_WAIT_RVALID;
      MEM_WAIT_RVALID:
        if (data_rvalid)
          state_d = ready_wb ? MEM_IDLE : MEM_DONE;
      MEM_DONE:
        if (ready_wb) state_d = MEM_IDLE;
      default: state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    data_req  = 1'b0;
    ready_mem = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        data_req  = need_bus & ~reset;
        ready_mem = ready_wb & ~need_bus;
      end
      MEM_WAIT_GNT:    data_req  = ~reset;
      MEM_WAIT_RVALID: ready_mem = ready_wb & data_rvalid;
      MEM_DONE:        ready_mem = ready_wb;
      default: begin
        data_req  = 1'b0;
        ready_mem = 1'b0;
      end
    endcase
  end

  // A flush after the request went out must still let the bus finish.
  always_ff @(posedge clk) begin
    if (reset)
      kill_q <= 1'b0;
    else if (state_q != MEM_IDLE && ready_mem)
      kill_q <= 1'b0;
    else if (state_q != MEM_IDLE && flush_M)
      kill_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      hold_q <= '0;
    else if (state_q == MEM_WAIT_RVALID && data_rvalid && !ready_wb)
      hold_q <= data_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_wr_en_wb   <= 1'b0;
      rd_wr_tag_wb  <= '0;
      rd_wr_addr_wb <= '0;
      rd_wr_data_wb <= '0;
      exc_taken_wb  <= 1'b0;
    end else if (ready_mem) begin
      rd_wr_en_wb   <= ~bubble & rd_wr_en_mem & ~exc_taken_mem
                     & ~misal_exc & ~(lsu_en_mem & is_st);
      rd_wr_tag_wb  <= rd_wr_tag_mem;
      rd_wr_addr_wb <= rd_wr_addr_mem;
      rd_wr_data_wb <= (lsu_en_mem & ~is_st) ? ld_data
                                             : rd_wr_data_mem;
      exc_taken_wb  <= ~bubble & (exc_taken_mem | misal_exc);
    end else if (ready_wb) begin
      rd_wr_en_wb  <= 1'b0;
      exc_taken_wb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: bus handshakes, lane steering,
// stalls, flush, exceptions and reset abandonment.
module tb_mem_stage;
  import riscv_pkg::*;

  logic                 clk;
  logic                 reset;
  logic                 flush_M;
  logic                 ready_wb;
  logic                 lsu_en_mem;
  logic                 lsu_en2;
  lsu_op_e              lsu_op_mem;
  lsu_dtype_e           lsu_dtype_mem;
  logic [31:0]          lsu_addr_mem;
  logic [31:0]          lsu_wdata_mem;
  logic                 rd_wr_en_mem;
  logic [TAG_WIDTH-1:0] rd_wr_tag_mem;
  logic [4:0]           rd_wr_addr_mem;
  logic [31:0]          rd_wr_data_mem;
  logic                 exc_taken_mem;
  logic                 data_gnt;
  logic                 data_rvalid;
  logic [31:0]          data_rdata;

  logic                 ready_mem;
  logic                 data_req;
  logic                 data_we;
  logic [3:0]           data_be;
  logic [31:0]          data_addr;
  logic [31:0]          data_wdata;
  logic                 rd_wr_en_wb;
  logic [TAG_WIDTH-1:0] rd_wr_tag_wb;
  logic [4:0]           rd_wr_addr_wb;
  logic [31:0]          rd_wr_data_wb;
  logic                 exc_taken_wb;

  logic                 ready_mem2;
  logic                 data_req2;
  logic                 data_we2;
  logic [3:0]           data_be2;
  logic [31:0]          data_addr2;
  logic [31:0]          data_wdata2;
  logic                 rd_wr_en_wb2;
  logic [TAG_WIDTH-1:0] rd_wr_tag_wb2;
  logic [4:0]           rd_wr_addr_wb2;
  logic [31:0]          rd_wr_data_wb2;
  logic                 exc_taken_wb2;

  int n_chk;
  int n_pass;

  mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .flush_M        (flush_M),
    .ready_wb       (ready_wb),
    .ready_mem      (ready_mem),
    .lsu_en_mem     (lsu_en_mem),
    .lsu_op_mem     (lsu_op_mem),
    .lsu_dtype_mem  (lsu_dtype_mem),
    .lsu_addr_mem   (lsu_addr_mem),
    .lsu_wdata_mem  (lsu_wdata_mem),
    .rd_wr_en_mem   (rd_wr_en_mem),
    .rd_wr_tag_mem  (rd_wr_tag_mem),
    .rd_wr_addr_mem (rd_wr_addr_mem),
    .rd_wr_data_mem (rd_wr_data_mem),
    .exc_taken_mem  (exc_taken_mem),
    .data_req       (data_req),
    .data_gnt       (data_gnt),
    .data_we        (data_we),
    .data_be        (data_be),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_rvalid    (data_rvalid),
    .data_rdata     (data_rdata),
    .rd_wr_en_wb    (rd_wr_en_wb),
    .rd_wr_tag_wb   (rd_wr_tag_wb),
    .rd_wr_addr_wb  (rd_wr_addr_wb),
    .rd_wr_data_wb  (rd_wr_data_wb),
    .exc_taken_wb   (exc_taken_wb)
  );

  mem_stage #(.MISALIGN_EXC_EN(1'b1)) dut_exc (
    .clk            (clk),
    .reset          (reset),
    .flush_M        (flush_M),
    .ready_wb       (ready_wb),
    .ready_mem      (ready_mem2),
    .lsu_en_mem     (lsu_en2),
    .lsu_op_mem     (lsu_op_mem),
    .lsu_dtype_mem  (lsu_dtype_mem),
    .lsu_addr_mem   (lsu_addr_mem),
    .lsu_wdata_mem  (lsu_wdata_mem),
    .rd_wr_en_mem   (rd_wr_en_mem),
    .rd_wr_tag_mem  (rd_wr_tag_mem),
    .rd_wr_addr_mem (rd_wr_addr_mem),
    .rd_wr_data_mem (rd_wr_data_mem),
    .exc_taken_mem  (exc_taken_mem),
    .data_req       (data_req2),
    .data_gnt       (data_gnt),
    .data_we        (data_we2),
    .data_be        (data_be2),
    .data_addr      (data_addr2),
    .data_wdata     (data_wdata2),
    .data_rvalid    (data_rvalid),
    .data_rdata     (data_rdata),
    .rd_wr_en_wb    (rd_wr_en_wb2),
    .rd_wr_tag_wb   (rd_wr_tag_wb2),
    .rd_wr_addr_wb  (rd_wr_addr_wb2),
    .rd_wr_data_wb  (rd_wr_data_wb2),
    .exc_taken_wb   (exc_taken_wb2)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb_zero(input string tag);
    chk({tag, "_en"},   32'(rd_wr_en_wb),   32'd0);
    chk({tag, "_tag"},  32'(rd_wr_tag_wb),  32'd0);
    chk({tag, "_addr"}, 32'(rd_wr_addr_wb), 32'd0);
    chk({tag, "_data"}, rd_wr_data_wb,      32'd0);
    chk({tag, "_exc"},  32'(exc_taken_wb),  32'd0);
  endtask

  task automatic lsu(
    input lsu_op_e     op,
    input lsu_dtype_e  dt,
    input logic [31:0] addr
  );
    lsu_en_mem    = 1'b1;
    lsu_op_mem    = op;
    lsu_dtype_mem = dt;
    lsu_addr_mem  = addr;
  endtask

  initial begin
    n_chk          = 0;
    n_pass         = 0;
    clk            = 1'b0;
    reset          = 1'b1;
    flush_M        = 1'b0;
    ready_wb       = 1'b1;
    lsu_en_mem     = 1'b1;
    lsu_en2        = 1'b0;
    lsu_op_mem     = LSU_OP_LD;
    lsu_dtype_mem  = LSU_LW;
    lsu_addr_mem   = 32'h0;
    lsu_wdata_mem  = 32'h0;
    rd_wr_en_mem   = 1'b0;
    rd_wr_tag_mem  = '0;
    rd_wr_addr_mem = '0;
    rd_wr_data_mem = 32'h0;
    exc_taken_mem  = 1'b0;
    data_gnt       = 1'b0;
    data_rvalid    = 1'b0;
    data_rdata     = 32'h0;

    #1 chk("rst_req", 32'(data_req), 32'd0);
    tick();
    tick();
    chk_wb_zero("rst");
    reset      = 1'b0;
    lsu_en_mem = 1'b0;

    // plain ALU result passes straight through
    rd_wr_en_mem   = 1'b1;
    rd_wr_tag_mem  = 4'd2;
    rd_wr_addr_mem = 5'd7;
    rd_wr_data_mem = 32'h1234_5678;
    #1;
    chk("alu_rdy", 32'(ready_mem), 32'd1);
    chk("alu_req", 32'(data_req), 32'd0);
    tick();
    chk("alu_en", 32'(rd_wr_en_wb), 32'd1);
    chk("alu_data", rd_wr_data_wb, 32'h1234_5678);
    chk("alu_addr", 32'(rd_wr_addr_wb), 32'd7);

    // WB stall holds the registers
    ready_wb       = 1'b0;
    rd_wr_data_mem = 32'hFFFF_FFFF;
    #1 chk("stall_rdy", 32'(ready_mem), 32'd0);
    tick();
    chk("stall_hold", rd_wr_data_wb, 32'h1234_5678);
    ready_wb = 1'b1;

    // LB 0x1003, gnt same cycle, rvalid next
    lsu(LSU_OP_LD, LSU_LB, 32'h0000_1003);
    rd_wr_tag_mem  = 4'd3;
    rd_wr_addr_mem = 5'd5;
    data_gnt       = 1'b1;
    #1;
    chk("lb_req", 32'(data_req), 32'd1);
    chk("lb_be", 32'(data_be), 32'h8);
    chk("lb_addr", data_addr, 32'h0000_1000);
    chk("lb_we", 32'(data_we), 32'd0);
    chk("lb_rdy0", 32'(ready_mem), 32'd0);
    tick();
    chk("lb_bubble", 32'(rd_wr_en_wb), 32'd0);
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h80FF_FF00;
    #1 chk("lb_rdy1", 32'(ready_mem), 32'd1);
    tick();
    chk("lb_data", rd_wr_data_wb, 32'hFFFF_FF80);
    chk("lb_en", 32'(rd_wr_en_wb), 32'd1);
    chk("lb_tag", 32'(rd_wr_tag_wb), 32'd3);
    data_rvalid = 1'b0;

    // SH 0x2002 with grant delayed three cycles
    lsu(LSU_OP_ST, LSU_LH, 32'h0000_2002);
    lsu_wdata_mem = 32'h0000_1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sh_req", 32'(data_req), 32'd1);
      chk("sh_be", 32'(data_be), 32'hC);
      chk("sh_wdata", data_wdata, 32'h1234_1234);
      chk("sh_addr", data_addr, 32'h0000_2000);
      chk("sh_we", 32'(data_we), 32'd1);
      tick();
    end
    data_gnt = 1'b1;
    #1 chk("sh_req_gnt", 32'(data_req), 32'd1);
    tick();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    #1 chk("sh_rdy", 32'(ready_mem), 32'd1);
    tick();
    chk("sh_en", 32'(rd_wr_en_wb), 32'd0);
    chk("sh_exc", 32'(exc_taken_wb), 32'd0);
    data_rvalid = 1'b0;

    // LHU 0x10 with WB stalled after the response
    lsu(LSU_OP_LD, LSU_LHU, 32'h0000_0010);
    rd_wr_addr_mem = 5'd9;
    data_gnt       = 1'b1;
    #1 chk("lhu_req", 32'(data_req), 32'd1);
    tick();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h0000_ABCD;
    ready_wb    = 1'b0;
    #1 chk("lhu_rv_rdy", 32'(ready_mem), 32'd0);
    tick();
    data_rvalid = 1'b0;
    data_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lhu_done_rdy", 32'(ready_mem), 32'd0);
      chk("lhu_done_req", 32'(data_req), 32'd0);
      tick();
    end
    ready_wb = 1'b1;
    #1 chk("lhu_done_go", 32'(ready_mem), 32'd1);
    tick();
    chk("lhu_data", rd_wr_data_wb, 32'h0000_ABCD);
    chk("lhu_en", 32'(rd_wr_en_wb), 32'd1);

    // misaligned LW ignored low bits when exceptions are off
    lsu(LSU_OP_LD, LSU_LW, 32'h0000_0006);
    data_gnt = 1'b1;
    #1;
    chk("lwm_req", 32'(data_req), 32'd1);
    chk("lwm_be", 32'(data_be), 32'hF);
    chk("lwm_addr", data_addr, 32'h0000_0004);
    tick();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'hCAFE_F00D;
    tick();
    chk("lwm_data", rd_wr_data_wb, 32'hCAFE_F00D);
    data_rvalid = 1'b0;

    // misaligned LW raises an exception on the checking instance
    lsu_en_mem = 1'b0;
    lsu_en2    = 1'b1;
    #1;
    chk("mx_req", 32'(data_req2), 32'd0);
    chk("mx_rdy", 32'(ready_mem2), 32'd1);
    tick();
    chk("mx_exc", 32'(exc_taken_wb2), 32'd1);
    chk("mx_en", 32'(rd_wr_en_wb2), 32'd0);
    lsu_en2 = 1'b0;

    // upstream exception blocks the bus
    lsu(LSU_OP_LD, LSU_LW, 32'h0000_0040);
    exc_taken_mem = 1'b1;
    data_gnt      = 1'b1;
    #1;
    chk("ux_req", 32'(data_req), 32'd0);
    chk("ux_rdy", 32'(ready_mem), 32'd1);
    tick();
    chk("ux_exc", 32'(exc_taken_wb), 32'd1);
    chk("ux_en", 32'(rd_wr_en_wb), 32'd0);
    exc_taken_mem = 1'b0;

    // flush while idle
    lsu_addr_mem = 32'h0000_0044;
    flush_M      = 1'b1;
    #1;
    chk("fi_req", 32'(data_req), 32'd0);
    chk("fi_rdy", 32'(ready_mem), 32'd1);
    tick();
    chk("fi_en", 32'(rd_wr_en_wb), 32'd0);
    chk("fi_exc", 32'(exc_taken_wb), 32'd0);
    flush_M = 1'b0;

    // flush while waiting for the response
    lsu_addr_mem = 32'h0000_0020;
    tick();
    data_gnt = 1'b0;
    flush_M  = 1'b1;
    #1 chk("fr_rdy0", 32'(ready_mem), 32'd0);
    tick();
    flush_M     = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h1111_1111;
    #1 chk("fr_rdy1", 32'(ready_mem), 32'd1);
    tick();
    chk("fr_en", 32'(rd_wr_en_wb), 32'd0);
    chk("fr_exc", 32'(exc_taken_wb), 32'd0);
    data_rvalid = 1'b0;

    // kill must not leak into the next instruction
    lsu_en_mem     = 1'b0;
    rd_wr_data_mem = 32'h55AA_55AA;
    tick();
    chk("post_kill_en", 32'(rd_wr_en_wb), 32'd1);
    chk("post_kill_data", rd_wr_data_wb, 32'h55AA_55AA);

    // reset abandons a transaction stuck in WAIT_GNT
    lsu(LSU_OP_LD, LSU_LW, 32'h0000_0030);
    tick();
    tick();
    #1 chk("rg_req_pre", 32'(data_req), 32'd1);
    reset = 1'b1;
    #1 chk("rg_req", 32'(data_req), 32'd0);
    tick();
    chk_wb_zero("rg");
    reset        = 1'b0;
    lsu_en_mem   = 1'b0;
    rd_wr_en_mem = 1'b0;
    data_rvalid  = 1'b1;
    data_rdata   = 32'h0000_0099;
    #1;
    chk("late_rdy", 32'(ready_mem), 32'd1);
    chk("late_req", 32'(data_req), 32'd0);
    tick();
    chk("late_en", 32'(rd_wr_en_wb), 32'd0);
    data_rvalid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
